ram_sync_read_arbiter2: RTL and testbench

//  Round-robin arbiter sharing one synchronous-read single-port RAM (one address
//  bus, separate din/dout, we, 1-cycle read latency) between two requesters.

---
 rtl/ram_sync_read_arbiter2_pkg.sv | 13 +
 rtl/ram_sync_read_arbiter2_grant.sv | 50 +++++
 rtl/ram_sync_read_arbiter2.sv | 126 ++++++++++++
 tb/tb_ram_sync_read_arbiter2.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_sync_read_arbiter2_pkg.sv
// Shared types for the two-way RAM arbiter.
// State encoding and requester-ID width.
package ram_sync_read_arbiter2_pkg;

  localparam int ID_W = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

endpackage

// File: rtl/ram_sync_read_arbiter2_grant.sv
// Combinational round-robin grant for two requesters.
// Ports: valid0/1, state, hold_cnt, last_owner in; grant0/1 out.
module rr_grant2
  import ram_sync_read_arbiter2_pkg::*;
#(
  parameter int MAX_HOLD = 4,
  parameter int HW       = $clog2(MAX_HOLD + 1)
) (
  input  logic            valid0,
  input  logic            valid1,
  input  state_t          state,
  input  logic [HW-1:0]   hold_cnt,
  input  logic [ID_W-1:0] last_owner,
  output logic            grant0,
  output logic            grant1
);

  localparam logic [HW-1:0] HMAX = HW'(MAX_HOLD);

  logic keep;

  assign keep = hold_cnt < HMAX;

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (valid0 && !valid1) begin
      grant0 = 1'b1;
    end else if (valid1 && !valid0) begin
      grant1 = 1'b1;
    end else if (valid0 && valid1) begin
      unique case (state)
        OWN0: begin
          grant0 = keep;
          grant1 = !keep;
        end
        OWN1: begin
          grant1 = keep;
          grant0 = !keep;
        end
        default: begin
          // Idle tie: favour whoever did not own last
          grant0 = last_owner != '0;
          grant1 = last_owner == '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/ram_sync_read_arbiter2.sv
// Round-robin arbiter sharing one sync-read RAM between two clients.
// Ports: clock/reset, req0/1 valid-ready requests, rsp0/1 read strobes, ram_*.
module ram_sync_read_arbiter2
  import ram_sync_read_arbiter2_pkg::*;
#(
  parameter int AWIDTH   = 3,
  parameter int DWIDTH   = 32,
  parameter int MAX_HOLD = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_we,
  input  logic [AWIDTH-1:0] req0_addr,
  input  logic [DWIDTH-1:0] req0_din,
  output logic              rsp0_valid,
  output logic [DWIDTH-1:0] rsp0_data,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_we,
  input  logic [AWIDTH-1:0] req1_addr,
  input  logic [DWIDTH-1:0] req1_din,
  output logic              rsp1_valid,
  output logic [DWIDTH-1:0] rsp1_data,
  output logic [AWIDTH-1:0] ram_addr,
  output logic [DWIDTH-1:0] ram_din,
  output logic              ram_we,
  input  logic [DWIDTH-1:0] ram_dout
);

  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HMAX = HW'(MAX_HOLD);

  state_t          state;
  state_t          state_nx;
  logic [HW-1:0]   hold_cnt;
  logic [HW-1:0]   hold_nx;
  logic [HW-1:0]   hold_inc;
  logic [ID_W-1:0] last_owner;
  logic [ID_W-1:0] last_nx;
  logic            g0;
  logic            g1;
  logic            gnt0;
  logic            gnt1;
  logic            rd0_q;
  logic            rd1_q;

  rr_grant2 #(
    .MAX_HOLD (MAX_HOLD),
    .HW       (HW)
  ) u_grant (
    .valid0     (req0_valid),
    .valid1     (req1_valid),
    .state      (state),
    .hold_cnt   (hold_cnt),
    .last_owner (last_owner),
    .grant0     (g0),
    .grant1     (g1)
  );

  // Nothing is granted while reset is held, so
  // an in-flight write never reaches the RAM.
  assign gnt0 = g0 & ~reset;
  assign gnt1 = g1 & ~reset;

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  assign hold_inc = (hold_cnt == HMAX) ?
                    HMAX : hold_cnt + HW'(1);

  always_comb begin
    ram_addr = '0;
    ram_din  = '0;
    ram_we   = 1'b0;
    if (gnt0) begin
      ram_addr = req0_addr;
      ram_din  = req0_din;
      ram_we   = req0_we;
    end else if (gnt1) begin
      ram_addr = req1_addr;
      ram_din  = req1_din;
      ram_we   = req1_we;
    end
  end

  always_comb begin
    state_nx = IDLE;
    hold_nx  = '0;
    last_nx  = last_owner;
    if (gnt0) begin
      state_nx = OWN0;
      last_nx  = '0;
      hold_nx  = (state == OWN0) ? hold_inc : HW'(1);
    end else if (gnt1) begin
      state_nx = OWN1;
      last_nx  = ID_W'(1);
      hold_nx  = (state == OWN1) ? hold_inc : HW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      hold_cnt   <= '0;
      last_owner <= ID_W'(1);
      rd0_q      <= 1'b0;
      rd1_q      <= 1'b0;
    end else begin
      state      <= state_nx;
      hold_cnt   <= hold_nx;
      last_owner <= last_nx;
      rd0_q      <= gnt0 & ~req0_we;
      rd1_q      <= gnt1 & ~req1_we;
    end
  end

  // Masking with reset drops a response that
  // lands in the reset cycle itself.
  assign rsp0_valid = rd0_q & ~reset;
  assign rsp1_valid = rd1_q & ~reset;
  assign rsp0_data  = rsp0_valid ? ram_dout : '0;
  assign rsp1_data  = rsp1_valid ? ram_dout : '0;

endmodule

// File: tb/tb_ram_sync_read_arbiter2.sv
// Directed and random bench for ram_sync_read_arbiter2.
// Includes a 1-cycle sync-read RAM model and a data scoreboard.
module tb_ram_sync_read_arbiter2;

  localparam int AW = 3;
  localparam int DW = 32;
  localparam int MH = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          req0_valid;
  logic          req0_ready;
  logic          req0_we;
  logic [AW-1:0] req0_addr;
  logic [DW-1:0] req0_din;
  logic          rsp0_valid;
  logic [DW-1:0] rsp0_data;
  logic          req1_valid;
  logic          req1_ready;
  logic          req1_we;
  logic [AW-1:0] req1_addr;
  logic [DW-1:0] req1_din;
  logic          rsp1_valid;
  logic [DW-1:0] rsp1_data;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic          ram_we;
  logic [DW-1:0] ram_dout;

  logic [DW-1:0] mem [1<<AW];
  logic [DW-1:0] sb  [1<<AW];

  int errors = 0;
  int checks = 0;
  int gseq [9];
  int rcnt;
  int wait0;
  int wait1;
  logic pend0;
  logic pend1;
  logic [DW-1:0] pdat0;
  logic [DW-1:0] pdat1;
  logic acc0;
  logic acc1;
  logic r0;
  logic r1;

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  ram_sync_read_arbiter2 #(
    .AWIDTH   (AW),
    .DWIDTH   (DW),
    .MAX_HOLD (MH)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_we    (req0_we),
    .req0_addr  (req0_addr),
    .req0_din   (req0_din),
    .rsp0_valid (rsp0_valid),
    .rsp0_data  (rsp0_data),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_we    (req1_we),
    .req1_addr  (req1_addr),
    .req1_din   (req1_din),
    .rsp1_valid (rsp1_valid),
    .rsp1_data  (rsp1_data),
    .ram_addr   (ram_addr),
    .ram_din    (ram_din),
    .ram_we     (ram_we),
    .ram_dout   (ram_dout)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic set0(input logic v, input logic we,
                      input int a, input logic [DW-1:0] d);
    req0_valid = v;
    req0_we    = we;
    req0_addr  = AW'(a);
    req0_din   = d;
  endtask

  task automatic set1(input logic v, input logic we,
                      input int a, input logic [DW-1:0] d);
    req1_valid = v;
    req1_we    = we;
    req1_addr  = AW'(a);
    req1_din   = d;
  endtask

  initial begin
    gseq = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
    reset = 1'b1;
    set0(1'b1, 1'b1, 1, 32'h5);
    set1(1'b0, 1'b0, 0, 32'h0);

    // reset state, with a request pending
    repeat (2) @(negedge clock);
    chk("rst_ready0", req0_ready, 1'b0);
    chk("rst_ready1", req1_ready, 1'b0);
    chk("rst_ram_we", ram_we, 1'b0);
    chk("rst_rsp0", rsp0_valid, 1'b0);
    chk("rst_rsp1", rsp1_valid, 1'b0);

    // 1: write then read addr 3 from req0
    reset = 1'b0;
    set0(1'b1, 1'b1, 3, 32'hDEADBEEF);
    #1;
    chk("t1_wr_ready0", req0_ready, 1'b1);
    chk("t1_wr_ready1", req1_ready, 1'b0);
    chk("t1_wr_we", ram_we, 1'b1);
    chk("t1_wr_addr", ram_addr, 3'd3);
    chk("t1_wr_din", ram_din, 32'hDEADBEEF);
    @(negedge clock);
    set0(1'b1, 1'b0, 3, 32'h0);
    #1;
    chk("t1_rd_ready0", req0_ready, 1'b1);
    chk("t1_rd_we", ram_we, 1'b0);
    chk("t1_wr_norsp", rsp0_valid, 1'b0);
    @(negedge clock);
    set0(1'b0, 1'b0, 0, 32'h0);
    #1;
    chk("t1_rsp0_valid", rsp0_valid, 1'b1);
    chk("t1_rsp0_data", rsp0_data, 32'hDEADBEEF);
    chk("t1_rsp1_valid", rsp1_valid, 1'b0);
    @(negedge clock);
    chk("t1_rsp0_off", rsp0_valid, 1'b0);
    chk("t1_data_zero", rsp0_data, 32'h0);

    // 2: contention out of reset
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    set0(1'b1, 1'b0, 3, 32'h0);
    set1(1'b1, 1'b0, 4, 32'h0);
    for (int i = 0; i < 9; i++) begin
      #1;
      chk("t2_ready0", req0_ready, gseq[i] == 0);
      chk("t2_ready1", req1_ready, gseq[i] == 1);
      if (i > 0) begin
        chk("t2_rsp0", rsp0_valid, gseq[i-1] == 0);
        chk("t2_rsp1", rsp1_valid, gseq[i-1] == 1);
        if (gseq[i-1] == 0)
          chk("t2_rsp0_data", rsp0_data, 32'hDEADBEEF);
      end
      @(negedge clock);
    end
    #1;
    chk("t2_last_rsp0", rsp0_valid, 1'b1);
    chk("t2_last_rsp1", rsp1_valid, 1'b0);

    // 3: only req1 for 10 cycles
    set0(1'b0, 1'b0, 0, 32'h0);
    rcnt = 0;
    for (int i = 0; i < 10; i++) begin
      set1(1'b1, 1'b0, i, 32'h0);
      #1;
      chk("t3_ready1", req1_ready, 1'b1);
      chk("t3_ready0", req0_ready, 1'b0);
      @(negedge clock);
      if (rsp1_valid) rcnt++;
    end
    set1(1'b0, 1'b0, 0, 32'h0);
    chk("t3_rsp_count", rcnt, 10);

    // 4: same-cycle write/read of addr 5
    @(negedge clock);
    set0(1'b1, 1'b1, 5, 32'h11);
    set1(1'b1, 1'b0, 5, 32'h0);
    #1;
    chk("t4_ready0", req0_ready, 1'b1);
    chk("t4_ready1", req1_ready, 1'b0);
    chk("t4_we", ram_we, 1'b1);
    chk("t4_addr", ram_addr, 3'd5);
    @(negedge clock);
    set0(1'b0, 1'b0, 0, 32'h0);
    #1;
    chk("t4_rd_ready1", req1_ready, 1'b1);
    chk("t4_rd_we", ram_we, 1'b0);
    chk("t4_rd_addr", ram_addr, 3'd5);
    @(negedge clock);
    set1(1'b0, 1'b0, 0, 32'h0);
    #1;
    chk("t4_rsp1_valid", rsp1_valid, 1'b1);
    chk("t4_rsp1_data", rsp1_data, 32'h11);
    chk("t4_rsp0_valid", rsp0_valid, 1'b0);

    // 5: reset right after a read is accepted
    @(negedge clock);
    set0(1'b1, 1'b0, 3, 32'h0);
    #1;
    chk("t5_ready0", req0_ready, 1'b1);
    @(negedge clock);
    reset = 1'b1;
    set0(1'b0, 1'b0, 0, 32'h0);
    set1(1'b1, 1'b1, 2, 32'hBAD);
    #1;
    chk("t5_rsp0_drop", rsp0_valid, 1'b0);
    chk("t5_rsp0_data", rsp0_data, 32'h0);
    chk("t5_ram_we", ram_we, 1'b0);
    chk("t5_ready1", req1_ready, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    set0(1'b1, 1'b0, 3, 32'h0);
    #1;
    chk("t5_after_rsp0", rsp0_valid, 1'b0);
    chk("t5_win_ready0", req0_ready, 1'b1);
    chk("t5_win_ready1", req1_ready, 1'b0);
    @(negedge clock);
    set0(1'b0, 1'b0, 0, 32'h0);
    set1(1'b0, 1'b0, 0, 32'h0);
    #1;
    chk("t5_rsp0_valid", rsp0_valid, 1'b1);
    chk("t5_rsp0_data", rsp0_data, 32'hDEADBEEF);

    // 6: prefill RAM, then random traffic
    for (int a = 0; a < (1 << AW); a++) begin
      @(negedge clock);
      sb[a] = $urandom;
      set0(1'b1, 1'b1, a, sb[a]);
    end
    @(negedge clock);
    set0(1'b0, 1'b0, 0, 32'h0);
    @(negedge clock);
    pend0 = 1'b0;
    pend1 = 1'b0;
    pdat0 = '0;
    pdat1 = '0;
    acc0  = 1'b0;
    acc1  = 1'b0;
    wait0 = 0;
    wait1 = 0;
    for (int c = 0; c < 2000; c++) begin
      chk("r_rsp0_valid", rsp0_valid, pend0);
      chk("r_rsp0_data", rsp0_data, pend0 ? pdat0 : '0);
      chk("r_rsp1_valid", rsp1_valid, pend1);
      chk("r_rsp1_data", rsp1_data, pend1 ? pdat1 : '0);
      if (!req0_valid || acc0)
        set0($urandom_range(0, 99) < 60,
             1'($urandom), $urandom_range(0, 7),
             $urandom);
      if (!req1_valid || acc1)
        set1($urandom_range(0, 99) < 60,
             1'($urandom), $urandom_range(0, 7),
             $urandom);
      #1;
      r0 = req0_ready;
      r1 = req1_ready;
      chk("r_both_ready", r0 & r1, 1'b0);
      chk("r_ready0_novalid", r0 & ~req0_valid, 1'b0);
      chk("r_ready1_novalid", r1 & ~req1_valid, 1'b0);
      chk("r_work", r0 | r1, req0_valid | req1_valid);
      if (r0) begin
        chk("r_addr0", ram_addr, req0_addr);
        chk("r_we0", ram_we, req0_we);
      end else if (r1) begin
        chk("r_addr1", ram_addr, req1_addr);
        chk("r_we1", ram_we, req1_we);
      end else begin
        chk("r_idle_we", ram_we, 1'b0);
        chk("r_idle_addr", ram_addr, 3'd0);
        chk("r_idle_din", ram_din, 32'h0);
      end
      wait0 = (req0_valid && !r0) ? wait0 + 1 : 0;
      wait1 = (req1_valid && !r1) ? wait1 + 1 : 0;
      chk("r_wait0", wait0 <= MH, 1'b1);
      chk("r_wait1", wait1 <= MH, 1'b1);
      pend0 = r0 && !req0_we;
      pend1 = r1 && !req1_we;
      if (pend0) pdat0 = sb[req0_addr];
      if (pend1) pdat1 = sb[req1_addr];
      if (r0 && req0_we) sb[req0_addr] = req0_din;
      if (r1 && req1_we) sb[req1_addr] = req1_din;
      acc0 = r0;
      acc1 = r1;
      @(negedge clock);
    end
    chk("r_end_rsp0", rsp0_valid, pend0);
    chk("r_end_rsp1", rsp1_valid, pend1);
    chk("r_end_data0", rsp0_data, pend0 ? pdat0 : '0);
    chk("r_end_data1", rsp1_data, pend1 ? pdat1 : '0);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
